rsnn_spike_tx: RTL and testbench

Chip-side transmitter that streams output-layer spike vectors of the RSNN core to the off-chip host. Each completed network timestep produces a frame: a header byte, then NUM_OUT/8 spike bytes. Each byte is placed on uo_out with a 4-phase req/ack handshake, and the host returns ack on a ui_in pin. The block sits between the RSNN core's output layer and the top-level pin mux, and is the sending end of the link the cocotb bench reads.

---
 rtl/rsnn_spike_tx_if.sv | 25 ++
 rtl/rsnn_spike_tx.sv | 124 ++++++++++++
 tb/tb_rsnn_spike_tx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/rsnn_spike_tx_if.sv
// Link bundle between the RSNN output layer, the host pins and the spike transmitter.
// master is the transmitter side; slave is the core/host side driving it.
interface rsnn_spike_tx_if #(
   parameter int NUM_OUT = 16
);
   logic               ena;
   logic [NUM_OUT-1:0] spikes_in;
   logic               spikes_valid;
   logic               host_ack;
   logic [7:0]         tx_data;
   logic               tx_req;
   logic               busy;
   logic               overflow;
   logic               frame_done;

   modport master (
      input  ena, spikes_in, spikes_valid, host_ack,
      output tx_data, tx_req, busy, overflow, frame_done
   );

   modport slave (
      output ena, spikes_in, spikes_valid, host_ack,
      input  tx_data, tx_req, busy, overflow, frame_done
   );
endinterface

// File: rtl/rsnn_spike_tx.sv
// Streams one frame per timestep (header = timestep count, then spike bytes LSB first)
// to the host over a 4-phase req/ack byte handshake with a one-deep pending buffer.
module rsnn_spike_tx #(
   parameter int NUM_OUT = 16
) (
   input logic              clk,
   input logic              reset,
   rsnn_spike_tx_if.master  link
);
   localparam int NBYTES = NUM_OUT / 8 + 1;
   localparam int IDX_W  = $clog2(NBYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

   state_t             state, state_next;
   logic               ack_meta, ack_s;
   logic [7:0]         ts_cnt;
   logic               pending, pending_next;
   logic [NUM_OUT-1:0] pend_spk;
   logic [7:0]         pend_ts;
   logic [NUM_OUT-1:0] act_sh, act_sh_next;
   logic [IDX_W-1:0]   idx, idx_next;
   logic [7:0]         data_next;
   logic               req_next;
   logic               done_next;
   logic               consume;
   logic               accept;

   // host_ack is asynchronous to clk; only ack_s is used beyond this point
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack_meta <= 1'b0;
         ack_s    <= 1'b0;
      end else begin
         ack_meta <= link.host_ack;
         ack_s    <= ack_meta;
      end
   end

   always_comb begin
      state_next  = state;
      idx_next    = idx;
      act_sh_next = act_sh;
      data_next   = link.tx_data;
      req_next    = link.tx_req;
      done_next   = 1'b0;
      consume     = 1'b0;
      case (state)
         IDLE: begin
            if (pending) begin
               consume     = 1'b1;
               act_sh_next = pend_spk;
               data_next   = pend_ts;
               req_next    = 1'b1;
               idx_next    = '0;
               state_next  = REQ;
            end
         end
         REQ: begin
            if (ack_s) begin
               req_next   = 1'b0;
               state_next = REL;
            end
         end
         REL: begin
            if (!ack_s) begin
               if (idx == LAST_IDX) begin
                  done_next  = 1'b1;
                  state_next = IDLE;
               end else begin
                  idx_next    = idx + 1'b1;
                  data_next   = act_sh[7:0];
                  act_sh_next = act_sh >> 8;
                  req_next    = 1'b1;
                  state_next  = REQ;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A capture on the same edge as the IDLE consume refills the freed slot without overflow
   always_comb begin
      accept       = link.ena && link.spikes_valid;
      pending_next = accept ? 1'b1 : (pending && !consume);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         idx             <= '0;
         act_sh          <= '0;
         pending         <= 1'b0;
         pend_spk        <= '0;
         pend_ts         <= 8'd0;
         ts_cnt          <= 8'd0;
         link.tx_data    <= 8'd0;
         link.tx_req     <= 1'b0;
         link.busy       <= 1'b0;
         link.overflow   <= 1'b0;
         link.frame_done <= 1'b0;
      end else begin
         state           <= state_next;
         idx             <= idx_next;
         act_sh          <= act_sh_next;
         pending         <= pending_next;
         link.tx_data    <= data_next;
         link.tx_req     <= req_next;
         link.frame_done <= done_next;
         link.busy       <= (state_next != IDLE) || pending_next;
         if (accept) begin
            ts_cnt <= ts_cnt + 8'd1;
            if (pending && !consume) begin
               link.overflow <= 1'b1;
            end else begin
               pend_spk <= link.spikes_in;
               pend_ts  <= ts_cnt;
            end
         end
      end
   end
endmodule

// File: tb/tb_rsnn_spike_tx.sv
// Directed bench for rsnn_spike_tx: a small host model acks bytes, a monitor
// collects each presented byte, and the main sequence compares against hand values.
module tb_rsnn_spike_tx;
   localparam int NUM_OUT = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks   = 0;
   int   errors   = 0;
   int   done_cnt = 0;
   bit   host_en  = 1'b0;
   bit   req_prev = 1'b0;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];

   rsnn_spike_tx_if #(.NUM_OUT(NUM_OUT)) link ();

   rsnn_spike_tx #(.NUM_OUT(NUM_OUT)) dut (
      .clk   (clk),
      .reset (reset),
      .link  (link)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [NUM_OUT-1:0] spk);
      @(negedge clk);
      link.ena          = en;
      link.spikes_in    = spk;
      link.spikes_valid = 1'b1;
      @(negedge clk);
      link.spikes_valid = 1'b0;
      link.ena          = 1'b1;
   endtask

   task automatic waitIdle(input int max_cycles);
      int n = 0;
      while (link.busy && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      checkOutput("idle_timeout", 32'(link.busy), 32'd0);
   endtask

   task automatic checkRx(input string tag);
      checkOutput({tag, "_len"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < rx_q.size()) checkOutput(tag, 32'(rx_q[i]), 32'(exp_q[i]));
      end
      rx_q.delete();
   endtask

   task automatic resetDut();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      rx_q.delete();
      done_cnt = 0;
   endtask

   // Host: raise ack two cycles after seeing req, drop it once req falls
   initial begin
      forever begin
         @(negedge clk);
         if (host_en) begin
            if (link.tx_req && !link.host_ack) begin
               repeat (2) @(negedge clk);
               link.host_ack = 1'b1;
            end else if (!link.tx_req && link.host_ack) begin
               link.host_ack = 1'b0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (link.tx_req && !req_prev) rx_q.push_back(link.tx_data);
         req_prev = link.tx_req;
         if (link.frame_done) done_cnt++;
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] b;
      int n;
      link.ena          = 1'b1;
      link.spikes_in    = '0;
      link.spikes_valid = 1'b0;
      link.host_ack     = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("rst_tx_data", 32'(link.tx_data), 32'h0);
      checkOutput("rst_tx_req", 32'(link.tx_req), 32'h0);
      checkOutput("rst_busy", 32'(link.busy), 32'h0);
      checkOutput("rst_overflow", 32'(link.overflow), 32'h0);
      checkOutput("rst_frame_done", 32'(link.frame_done), 32'h0);
      reset = 1'b0;

      // Single frame with capture latency
      host_en = 1'b1;
      applyStimulus(1'b1, 16'hA55A);
      checkOutput("cap_busy", 32'(link.busy), 32'h1);
      checkOutput("cap_req", 32'(link.tx_req), 32'h0);
      @(negedge clk);
      checkOutput("req_on", 32'(link.tx_req), 32'h1);
      checkOutput("hdr_first", 32'(link.tx_data), 32'h00);
      waitIdle(300);
      exp_q = '{8'h00, 8'h5A, 8'hA5};
      checkRx("single");
      checkOutput("single_done", done_cnt, 32'd1);
      checkOutput("single_ovf", 32'(link.overflow), 32'h0);
      done_cnt = 0;

      // Back-to-back: second strobe lands while the first frame is in flight
      applyStimulus(1'b1, 16'h1234);
      repeat (4) @(negedge clk);
      applyStimulus(1'b1, 16'h0F0F);
      waitIdle(600);
      exp_q = '{8'h01, 8'h34, 8'h12, 8'h02, 8'h0F, 8'h0F};
      checkRx("b2b");
      checkOutput("b2b_done", done_cnt, 32'd2);
      checkOutput("b2b_ovf", 32'(link.overflow), 32'h0);

      // Overflow: host withholds ack across three strobes
      host_en = 1'b0;
      resetDut();
      applyStimulus(1'b1, 16'h1111);
      applyStimulus(1'b1, 16'h2222);
      applyStimulus(1'b1, 16'h3333);
      checkOutput("ovf_set", 32'(link.overflow), 32'h1);
      checkOutput("ovf_busy", 32'(link.busy), 32'h1);
      checkOutput("ovf_stall_req", 32'(link.tx_req), 32'h1);
      host_en = 1'b1;
      waitIdle(600);
      exp_q = '{8'h00, 8'h11, 8'h11, 8'h01, 8'h22, 8'h22};
      checkRx("ovf_frames");
      applyStimulus(1'b1, 16'h4444);
      waitIdle(300);
      exp_q = '{8'h03, 8'h44, 8'h44};
      checkRx("ovf_next");
      checkOutput("ovf_sticky", 32'(link.overflow), 32'h1);

      // Handshake ordering: ack held high for 20 cycles
      host_en = 1'b0;
      applyStimulus(1'b1, 16'hBEEF);
      @(negedge clk);
      checkOutput("hs_req_on", 32'(link.tx_req), 32'h1);
      checkOutput("hs_hdr", 32'(link.tx_data), 32'h04);
      link.host_ack = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         checkOutput("hs_data_hold", 32'(link.tx_data), 32'h04);
         if (i >= 3) checkOutput("hs_req_low", 32'(link.tx_req), 32'h0);
      end
      link.host_ack = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("hs_req_wait", 32'(link.tx_req), 32'h0);
      checkOutput("hs_data_wait", 32'(link.tx_data), 32'h04);
      @(negedge clk);
      checkOutput("hs_req_next", 32'(link.tx_req), 32'h1);
      checkOutput("hs_byte1", 32'(link.tx_data), 32'hEF);
      host_en = 1'b1;
      waitIdle(300);
      exp_q = '{8'h04, 8'hEF, 8'hBE};
      checkRx("hs_frame");

      // Asynchronous reset after byte 1 has been presented
      applyStimulus(1'b1, 16'h5555);
      n = 0;
      while (rx_q.size() < 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("mid_byte1_seen", rx_q.size(), 32'd2);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      checkOutput("mid_tx_data", 32'(link.tx_data), 32'h0);
      checkOutput("mid_tx_req", 32'(link.tx_req), 32'h0);
      checkOutput("mid_busy", 32'(link.busy), 32'h0);
      checkOutput("mid_overflow", 32'(link.overflow), 32'h0);
      checkOutput("mid_frame_done", 32'(link.frame_done), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      rx_q.delete();
      done_cnt = 0;
      applyStimulus(1'b1, 16'h6789);
      waitIdle(300);
      exp_q = '{8'h00, 8'h89, 8'h67};
      checkRx("post_rst");
      checkOutput("post_rst_done", done_cnt, 32'd1);

      // Timestep counter wrap, then a strobe with ena low
      resetDut();
      for (int i = 0; i < 256; i++) begin
         b = 8'(i);
         applyStimulus(1'b1, {~b, b});
         waitIdle(300);
         exp_q = '{b, b, ~b};
         checkRx("wrap");
      end
      applyStimulus(1'b0, 16'hFFFF);
      repeat (5) @(negedge clk);
      checkOutput("ena0_busy", 32'(link.busy), 32'h0);
      checkOutput("ena0_frame", rx_q.size(), 32'd0);
      applyStimulus(1'b1, 16'h0102);
      waitIdle(300);
      exp_q = '{8'h00, 8'h02, 8'h01};
      checkRx("wrap_hdr0");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
